fifo_sync_flex: RTL

- Parametrised single-clock FIFO; next generation of the team's sync FIFO.
- Adds the following over the previous generation:
  - read mode fixed at elaboration (standard or first-word-fall-through);
  - occupancy count;
  - programmable almost-full and almost-empty flags;
  - synchronous flush.
- Storage is an inferred dual-port RAM with registered read address (1-cycle read latency).
- Used as the generic buffering element between streaming producers and consumers on one clock.

---
 rtl/fifo_sync_flex.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with elaboration-time read mode (standard / first-word-fall-through),
// occupancy count, almost-full/empty flags and flush. Define FIFO_ERR_FLAGS_EN for sticky ovf/udf.
module fifo_sync_flex #(
    parameter int unsigned ADDR_SIZE = 10,
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AF_LEVEL  = 2**ADDR_SIZE - 4,
    parameter int unsigned AE_LEVEL  = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 we,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic                 full,
    output logic                 almost_full,
    input  logic                 re,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 rvalid,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 ovf,
    output logic                 udf
);
    localparam int unsigned DEPTH = 2**ADDR_SIZE;

    typedef logic [ADDR_SIZE:0] cnt_t;

    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);
    localparam cnt_t AF_CNT    = cnt_t'(AF_LEVEL);
    localparam cnt_t AE_CNT    = cnt_t'(AE_LEVEL);
    localparam cnt_t PTR_ONE   = cnt_t'(1);

    if (AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_levels
        $error("fifo_sync_flex: levels must satisfy AE_LEVEL < AF_LEVEL <= 2**ADDR_SIZE");
    end

    logic [WORD_SIZE-1:0] mem [DEPTH];
    cnt_t                 wr_ptr;
    cnt_t                 rd_ptr;
    cnt_t                 count_q;
    logic                 clear;
    logic                 wr_acc;
    logic                 pop_acc;

    assign clear        = !rstn || flush;
    assign full         = (count_q == DEPTH_CNT);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;
    assign wr_acc       = !clear && we && !full;
    assign pop_acc      = !clear && re && !empty;

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (wr_acc && !pop_acc) begin
                count_q <= count_q + PTR_ONE;
            end else if (pop_acc && !wr_acc) begin
                count_q <= count_q - PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_SIZE-1:0]] <= wdata;
        end
    end

    if (FWFT == 0) begin : g_std
        logic [WORD_SIZE-1:0] rdata_q;
        logic                 rvalid_q;

        assign empty  = (count_q == '0);
        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;

        always_ff @(posedge clk) begin
            if (clear) begin
                rd_ptr   <= '0;
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= pop_acc;
                if (pop_acc) begin
                    rdata_q <= mem[rd_ptr[ADDR_SIZE-1:0]];
                    rd_ptr  <= rd_ptr + PTR_ONE;
                end
            end
        end
    end else begin : g_fwft
        // Two-stage prefetch: mid holds the word read from RAM, out is the visible head.
        // mid refills on the same edge it hands over, so back-to-back pops see no bubble.
        logic [WORD_SIZE-1:0] mid_q;
        logic [WORD_SIZE-1:0] out_q;
        logic                 mid_valid;
        logic                 out_valid;
        logic                 stored;
        logic                 out_free;
        logic                 mid_move;
        logic                 fetch;

        assign stored   = (wr_ptr != rd_ptr);
        assign out_free = !out_valid || pop_acc;
        assign mid_move = mid_valid && out_free;
        assign fetch    = stored && (!mid_valid || mid_move);

        assign empty  = !out_valid;
        assign rvalid = out_valid;
        assign rdata  = out_q;

        always_ff @(posedge clk) begin
            if (clear) begin
                rd_ptr    <= '0;
                mid_q     <= '0;
                mid_valid <= 1'b0;
                out_q     <= '0;
                out_valid <= 1'b0;
            end else begin
                if (fetch) begin
                    mid_q  <= mem[rd_ptr[ADDR_SIZE-1:0]];
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                if (fetch) begin
                    mid_valid <= 1'b1;
                end else if (mid_move) begin
                    mid_valid <= 1'b0;
                end
                if (mid_move) begin
                    out_q     <= mid_q;
                    out_valid <= 1'b1;
                end else if (pop_acc) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic udf_q;

    // Cleared by rstn only; flush deliberately leaves the error history intact.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (we && full) begin
                ovf_q <= 1'b1;
            end
            if (re && empty) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule
